// File: rtl/floating_divider.sv
// floating_divider: sequential IEEE-754 single divide c=a/b, restoring 1 bit/clk, truncating, FTZ; ports CLK/RST (sync high), a/b/start in, c/busy/done/div_by_zero registered out
module floating_divider (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] c,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
  state_t state;
  logic sign, spec, spec_dbz, za, zb, ia, ib, sp_in, nan_in, dbz_in, ge;
  logic [31:0] spec_c, sc, res;
  logic [7:0] ea, eb;
  logic [23:0] mb;
  logic [24:0] r, q, rn;
  logic [4:0] cnt;
  logic signed [9:0] e0, e;
  always_comb begin
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ia = a[30:23] == 8'hFF && a[22:0] == 23'd0;
    ib = b[30:23] == 8'hFF && b[22:0] == 23'd0;
    sp_in = za || zb || a[30:23] == 8'hFF || b[30:23] == 8'hFF;
    nan_in = (a[30:23] == 8'hFF && !ia) || (b[30:23] == 8'hFF && !ib) || (za && zb) || (ia && ib);
    dbz_in = !nan_in && zb && !ia;
    sc = nan_in ? 32'h7FC00000 : (dbz_in || ia) ? {a[31] ^ b[31], 8'hFF, 23'd0} : {a[31] ^ b[31], 31'd0};
    ge = r >= {1'b0, mb};
    rn = ge ? r - {1'b0, mb} : r;
    e0 = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
    e = q[24] ? e0 + 10'sd1 : e0;
    res = e >= 10'sd255 ? {sign, 8'hFF, 23'd0} : e <= 10'sd0 ? {sign, 31'd0} : {sign, e[7:0], q[24] ? q[23:1] : q[22:0]};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      c <= 32'd0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            sign <= a[31] ^ b[31];
            ea <= a[30:23];
            eb <= b[30:23];
            mb <= {1'b1, b[22:0]};
            r <= {2'b01, a[22:0]};
            q <= 25'd0;
            cnt <= 5'd0;
            spec <= sp_in;
            spec_c <= sc;
            spec_dbz <= dbz_in;
            state <= sp_in ? FIN : DIV;
          end
        end
        DIV: begin
          q <= {q[23:0], ge};
          r <= {rn[23:0], 1'b0};
          cnt <= cnt + 5'd1;
          state <= cnt == 5'd24 ? FIN : DIV;
        end
        FIN: begin
          c <= spec ? spec_c : res;
          div_by_zero <= spec && spec_dbz;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_divider.sv
// tb_floating_divider: self-checking bench for floating_divider against a value-level reference model
module tb_floating_divider;
  logic CLK = 1'b0, RST, start, busy, done, div_by_zero;
  logic [31:0] a, b, c;
  int tests = 0, fails = 0;
  floating_divider dut (.CLK(CLK), .RST(RST), .a(a), .b(b), .start(start), .c(c), .busy(busy), .done(done), .div_by_zero(div_by_zero));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r, output logic z, output logic sp);
    logic s;
    int ex, ey;
    bit zx, zy, ix, iy, nx, ny;
    longint qt, e;
    s = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = ex == 0;
    zy = ey == 0;
    ix = ex == 255 && x[22:0] == 0;
    iy = ey == 255 && y[22:0] == 0;
    nx = ex == 255 && x[22:0] != 0;
    ny = ey == 255 && y[22:0] != 0;
    z = 0;
    sp = zx || zy || ex == 255 || ey == 255;
    if (nx || ny || (zx && zy) || (ix && iy)) r = 32'h7FC00000;
    else if (zy && !ix) begin r = {s, 8'hFF, 23'd0}; z = 1; end
    else if (ix) r = {s, 8'hFF, 23'd0};
    else if (zx || iy) r = {s, 31'd0};
    else begin
      qt = (longint'({1'b1, x[22:0]}) << 26) / longint'({1'b1, y[22:0]});
      e = longint'(ex - ey + 127);
      if (qt < (64'sd1 <<< 26)) begin qt = qt << 1; e = e - 1; end
      if (e >= 255) r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else r = {s, e[7:0], qt[25:3]};
    end
  endfunction
  function automatic logic [31:0] rnd();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) v[30:23] = 8'd0;
    else if (k == 1) begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
    else if (k == 2) v[30:23] = 8'hFF;
    else if (k < 10) v[30:23] = 8'(100 + $urandom_range(0, 55));
    return v;
  endfunction
  task automatic wait_done(output int n, output bit ok, input logic [31:0] prev);
    ok = 1;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin n = i; ok = ok && busy === 1'b0; return; end
      ok = ok && busy === 1'b1 && c === prev;
    end
  endtask
  task automatic run(input logic [31:0] x, input logic [31:0] y, output logic [31:0] rc, output logic rz, output int lat, output bit ok);
    logic [31:0] prev;
    @(negedge CLK);
    a = x;
    b = y;
    start = 1'b1;
    prev = c;
    @(posedge CLK);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(lat, ok, prev);
    rc = c;
    rz = div_by_zero;
  endtask
  logic [31:0] da [8] = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h7F000000, 32'h00800000};
  logic [31:0] db [8] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000};
  logic [31:0] dc [8] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0800000, 32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h00000000};
  logic [7:0] dz = 8'b00001000;
  logic [7:0] dsp = 8'b00111000;
  initial begin
    logic [31:0] rc, mc;
    logic rz, mz, msp;
    int lat, seen;
    bit ok;
    RST = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_c", c, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run(da[i], db[i], rc, rz, lat, ok);
      check($sformatf("dir%0d_c", i), rc, dc[i]);
      check($sformatf("dir%0d_dbz", i), {31'd0, rz}, {31'd0, dz[i]});
      check($sformatf("dir%0d_lat", i), lat, dsp[i] ? 1 : 26);
      check($sformatf("dir%0d_hs", i), {31'd0, ok}, 32'd1);
    end
    @(negedge CLK);
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(lat, ok, 32'h00000000);
    check("ign_lat", lat, 21);
    check("ign_c", c, 32'h40400000);
    @(negedge CLK);
    a = 32'hC1000000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge CLK);
    #1;
    a = 32'h40C00000;
    b = 32'h40000000;
    wait_done(lat, ok, 32'h40400000);
    check("b2b1_lat", lat, 26);
    check("b2b1_c", c, 32'hC0800000);
    @(posedge CLK);
    #1;
    start = 1'b0;
    check("b2b2_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, ok, 32'hC0800000);
    check("b2b2_lat", lat, 26);
    check("b2b2_c", c, 32'h40400000);
    @(negedge CLK);
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_c", c, 32'd0);
    check("mid_dbz", {31'd0, div_by_zero}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (done) seen++;
    end
    check("mid_nodone", seen, 0);
    run(32'h3F800000, 32'h40400000, rc, rz, lat, ok);
    check("fresh_c", rc, 32'h3EAAAAAA);
    check("fresh_lat", lat, 26);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] x, y;
      x = rnd();
      y = rnd();
      model(x, y, mc, mz, msp);
      run(x, y, rc, rz, lat, ok);
      check($sformatf("rnd%0d_c %h/%h", i, x, y), rc, mc);
      check($sformatf("rnd%0d_dbz", i), {31'd0, rz}, {31'd0, mz});
      check($sformatf("rnd%0d_lat", i), lat, msp ? 1 : 26);
      check($sformatf("rnd%0d_hs", i), {31'd0, ok}, 32'd1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
